// File: rtl/scc_tone_sequencer_pkg.sv
// Shared constants and types for the SCC tone sequencer (package scc_pkg).
package scc_pkg;

  localparam int unsigned SCC_CH_NUM   = 5;
  localparam int unsigned SCC_SLOT_NUM = 6;
  localparam int unsigned SCC_FREQ_W   = 12;
  localparam int unsigned SCC_PTR_W    = 5;
  localparam int unsigned SCC_MIX_W    = 15;
  localparam int unsigned SCC_SMP_W    = 8;
  localparam int unsigned SCC_VOL_W    = 4;
  localparam int unsigned SCC_PROD_W   = 12;

  typedef logic [2:0] scc_slot_t;

endpackage

// File: rtl/scc_tone_sequencer_if.sv
// Wave-RAM read bus between the tone sequencer (master) and the wave RAM (slave).
interface scc_wave_if import scc_pkg::*; ();

  scc_slot_t                    wave_id;
  logic [SCC_PTR_W-1:0]         wave_a;
  logic                         wave_rd;
  logic signed [SCC_SMP_W-1:0]  wave_q;
  logic                         wave_q_en;

  modport master (output wave_id, wave_a, wave_rd, input wave_q, wave_q_en);
  modport slave  (input wave_id, wave_a, wave_rd, output wave_q, wave_q_en);

endinterface

// File: rtl/scc_tone_sequencer_volume_mac.sv
// Stage 1 (sample x volume) and stage 2 (enable-gated accumulate) plus the
// frame-close register that publishes the five-channel mix on slot 0.
module scc_volume_mac import scc_pkg::*; (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  scc_slot_t                    active,
  input  logic signed [SCC_SMP_W-1:0]  sample,
  input  logic [SCC_VOL_W-1:0]         reg_volume,
  input  logic                         reg_enable,
  input  logic                         mute,
  output logic signed [SCC_MIX_W-1:0]  mix_out,
  output logic                         mix_valid
);

  logic signed [SCC_PROD_W-1:0] product;
  logic signed [SCC_MIX_W-1:0]  acc;

  logic signed [SCC_PROD_W-1:0] smp_ext_c;
  logic signed [SCC_PROD_W-1:0] vol_ext_c;
  logic signed [SCC_PROD_W-1:0] prod_c;
  logic signed [SCC_MIX_W-1:0]  term_c;
  logic signed [SCC_MIX_W-1:0]  sum_c;

  // Volume is unsigned, so zero-extend it before the signed multiply.
  always_comb begin
    smp_ext_c = SCC_PROD_W'(sample);
    vol_ext_c = $signed(SCC_PROD_W'(reg_volume));
    prod_c    = smp_ext_c * vol_ext_c;
    term_c    = reg_enable ? SCC_MIX_W'(product) : '0;
    sum_c     = acc + term_c;
  end

  // Slot 1 carries the idle slot's stage 2, so nothing is added there.
  always_ff @(posedge clk) begin
    if (reset) begin
      product   <= '0;
      acc       <= '0;
      mix_out   <= '0;
      mix_valid <= 1'b0;
    end else begin
      mix_valid <= 1'b0;
      if (enable) begin
        product <= mute ? '0 : prod_c;
        if (active == scc_slot_t'(0)) begin
          mix_out   <= sum_c;
          mix_valid <= 1'b1;
          acc       <= '0;
        end else if (active != scc_slot_t'(1)) begin
          acc <= sum_c;
        end
      end
    end
  end

endmodule

// File: rtl/scc_tone_sequencer.sv
// SCC per-channel tone engine: slot sequencing, period counters, wave pointers.
// Optional SCC_LOW_FREQ_MUTE_EN freezes and mutes channels with frequency <= 8.
module scc_tone_sequencer import scc_pkg::*; #(
  parameter int unsigned CH_NUM   = SCC_CH_NUM,
  parameter int unsigned SLOT_NUM = SCC_SLOT_NUM
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  output scc_slot_t                    active,
  input  logic [SCC_FREQ_W-1:0]        reg_frequency_count,
  input  logic [SCC_VOL_W-1:0]         reg_volume,
  input  logic                         reg_enable,
  input  logic                         reg_wave_reset,
  input  logic [CH_NUM-1:0]            clear_counter,
  scc_wave_if.master                   wave,
  output logic signed [SCC_MIX_W-1:0]  mix_out,
  output logic                         mix_valid
);

`ifdef SCC_LOW_FREQ_MUTE_EN
  localparam logic [SCC_FREQ_W-1:0] MUTE_FREQ_MAX = SCC_FREQ_W'(8);
`endif

  logic [SCC_FREQ_W-1:0]        cnt [CH_NUM];
  logic [SCC_PTR_W-1:0]         ptr [CH_NUM];
  logic signed [SCC_SMP_W-1:0]  sample;
  logic                         mute;
  logic                         rd_req;
  scc_slot_t                    rd_id;
  logic [SCC_PTR_W-1:0]         rd_addr;

  scc_slot_t                    slot_nxt_c;
  scc_slot_t                    ch_c;
  logic                         is_ch_c;
  logic                         hold_c;
  logic [SCC_FREQ_W-1:0]        cnt_nxt_c;
  logic [SCC_PTR_W-1:0]         ptr_nxt_c;

  // Stage 0 next values for the channel owning the current slot; clear beats zero-count.
  always_comb begin
    slot_nxt_c = (active == scc_slot_t'(SLOT_NUM - 1)) ? '0 : active + scc_slot_t'(1);
    is_ch_c    = active < scc_slot_t'(CH_NUM);
    ch_c       = is_ch_c ? active : '0;
    hold_c     = 1'b0;
`ifdef SCC_LOW_FREQ_MUTE_EN
    hold_c     = reg_frequency_count <= MUTE_FREQ_MAX;
`endif
    cnt_nxt_c  = cnt[ch_c];
    ptr_nxt_c  = ptr[ch_c];
    if (!hold_c) begin
      if (clear_counter[ch_c]) begin
        cnt_nxt_c = reg_frequency_count;
        if (reg_wave_reset) begin
          ptr_nxt_c = '0;
        end
      end else if (cnt[ch_c] == '0) begin
        cnt_nxt_c = reg_frequency_count;
        ptr_nxt_c = ptr[ch_c] + SCC_PTR_W'(1);
      end else begin
        cnt_nxt_c = cnt[ch_c] - SCC_FREQ_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active <= '0;
      for (int unsigned i = 0; i < CH_NUM; i++) begin
        cnt[i] <= '0;
        ptr[i] <= '0;
      end
      sample  <= '0;
      mute    <= 1'b0;
      rd_req  <= 1'b0;
      rd_id   <= '0;
      rd_addr <= '0;
    end else begin
      rd_req <= 1'b0;
      if (wave.wave_q_en) begin
        sample <= wave.wave_q;
      end
      if (enable) begin
        active <= slot_nxt_c;
        mute   <= is_ch_c & hold_c;
        if (is_ch_c) begin
          cnt[ch_c] <= cnt_nxt_c;
          ptr[ch_c] <= ptr_nxt_c;
          rd_req    <= 1'b1;
          rd_id     <= active;
          rd_addr   <= ptr[ch_c];
        end
      end
    end
  end

  assign wave.wave_rd = rd_req;
  assign wave.wave_id = rd_id;
  assign wave.wave_a  = rd_addr;

  scc_volume_mac u_mac (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .active     (active),
    .sample     (sample),
    .reg_volume (reg_volume),
    .reg_enable (reg_enable),
    .mute       (mute),
    .mix_out    (mix_out),
    .mix_valid  (mix_valid)
  );

endmodule

// File: tb/tb_scc_tone_sequencer.sv
// Randomized bench for scc_tone_sequencer against a frame-level reference model.
module tb_scc_tone_sequencer;
  import scc_pkg::*;

`ifdef SCC_LOW_FREQ_MUTE_EN
  localparam int B_CHANGES_EXP = 0;
  localparam int A_WRAP_EXP    = 0;
`else
  localparam int B_CHANGES_EXP = 11;
  localparam int A_WRAP_EXP    = 1;
`endif

  logic               clk = 1'b0;
  logic               reset;
  logic               enable;
  scc_slot_t          active;
  logic [11:0]        reg_frequency_count;
  logic [3:0]         reg_volume;
  logic               reg_enable;
  logic               reg_wave_reset;
  logic [4:0]         clear_counter;
  logic signed [14:0] mix_out;
  logic               mix_valid;

  scc_wave_if wave ();

  scc_tone_sequencer dut (
    .clk                 (clk),
    .reset               (reset),
    .enable              (enable),
    .active              (active),
    .reg_frequency_count (reg_frequency_count),
    .reg_volume          (reg_volume),
    .reg_enable          (reg_enable),
    .reg_wave_reset      (reg_wave_reset),
    .clear_counter       (clear_counter),
    .wave                (wave.master),
    .mix_out             (mix_out),
    .mix_valid           (mix_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Register-block contents and wave RAM seen by the DUT
  int       freq [5];
  int       vol  [5];
  bit       en   [5];
  byte      ram  [5][32];
  bit       wave_rst;
  bit [4:0] clr_vec;

  // Reference model: per-channel period/pointer plus expected frame mixes
  typedef struct { int val; bit chk; } exp_t;
  int   m_slot;
  int   m_cnt [5];
  int   m_ptr [5];
  int   fsum;
  exp_t exp_q [$];
  int   obs_a [5];

  function automatic bit mute_of(input int f);
`ifdef SCC_LOW_FREQ_MUTE_EN
    return f <= 8;
`else
    return (f < 0);
`endif
  endfunction

  task automatic model_reset();
    exp_t e;
    m_slot = 0;
    fsum   = 0;
    for (int i = 0; i < 5; i++) begin
      m_cnt[i] = 0;
      m_ptr[i] = 0;
    end
    exp_q.delete();
    e.val = 0;
    e.chk = 1'b1;
    exp_q.push_back(e);
  endtask

  // Channel E's gate for a finished frame is applied after the next config change.
  task automatic mark_pending_skip();
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_back();
      e.chk = 1'b0;
      exp_q.push_back(e);
    end
  endtask

  task automatic drive_regs();
    int a, vi, ei;
    a  = int'(active);
    vi = (a + 5) % 6;
    ei = (a + 4) % 6;
    if (a < 5) reg_frequency_count = 12'(freq[a]);
    else       reg_frequency_count = 12'($urandom);
    if (vi < 5) reg_volume = 4'(vol[vi]);
    else        reg_volume = 4'd15;
    if (ei < 5) reg_enable = en[ei];
    else        reg_enable = 1'b1;
  endtask

  task automatic do_slot();
    int   s, nxt, smp;
    exp_t e;
    s   = m_slot;
    nxt = (s == 5) ? 0 : s + 1;
    drive_regs();
    clear_counter  = clr_vec;
    reg_wave_reset = wave_rst;
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    check_eq("active", int'(active), nxt);
    check_eq("wave_rd", wave.wave_rd, s < 5);
    check_eq("mix_valid", mix_valid, s == 0);
    if (s == 0) begin
      e = exp_q.pop_front();
      if (e.chk) check_eq("mix_out", mix_out, e.val);
    end
    if (s < 5) begin
      check_eq("wave_id", int'(wave.wave_id), s);
      check_eq("wave_a", int'(wave.wave_a), m_ptr[s]);
      obs_a[s] = int'(wave.wave_a);
      smp  = int'(ram[s][m_ptr[s]]);
      fsum += (en[s] && !mute_of(freq[s])) ? smp * vol[s] : 0;
      if (s == 4) begin
        e.val = fsum;
        e.chk = 1'b1;
        exp_q.push_back(e);
        fsum = 0;
      end
      if (!mute_of(freq[s])) begin
        if (clr_vec[s]) begin
          m_cnt[s] = freq[s];
          if (wave_rst) m_ptr[s] = 0;
        end else if (m_cnt[s] == 0) begin
          m_cnt[s] = freq[s];
          m_ptr[s] = (m_ptr[s] + 1) % 32;
        end else begin
          m_cnt[s] = m_cnt[s] - 1;
        end
      end
    end
    if (wave.wave_rd) begin
      wave.wave_q    = ram[wave.wave_id][wave.wave_a];
      wave.wave_q_en = 1'b1;
    end
    @(negedge clk);
    wave.wave_q_en = 1'b0;
    check_eq("rd_pulse", wave.wave_rd, 0);
    repeat (2) @(negedge clk);
    m_slot = nxt;
  endtask

  task automatic run_frames(input int n);
    repeat (n * 6) do_slot();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check_eq("rst_active", int'(active), 0);
    check_eq("rst_wave_rd", wave.wave_rd, 0);
    check_eq("rst_wave_id", int'(wave.wave_id), 0);
    check_eq("rst_wave_a", int'(wave.wave_a), 0);
    check_eq("rst_mix_out", mix_out, 0);
    check_eq("rst_mix_valid", mix_valid, 0);
  endtask

  task automatic random_config();
    for (int i = 0; i < 5; i++) begin
      freq[i] = $urandom_range(0, 12);
      vol[i]  = $urandom_range(0, 15);
      en[i]   = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    int prev_a0, prev_a1, b_changes, saw_wrap;
    reset = 1'b1; enable = 1'b0; clear_counter = '0; reg_wave_reset = 1'b0;
    reg_frequency_count = '0; reg_volume = '0; reg_enable = 1'b0;
    wave.wave_q = '0; wave.wave_q_en = 1'b0;
    clr_vec = '0; wave_rst = 1'b0;
    freq = '{2, 8, 5, 100, 0};
    vol  = '{1, 3, 15, 7, 0};
    en   = '{1, 1, 0, 1, 1};
    for (int c = 0; c < 5; c++)
      for (int a = 0; a < 32; a++)
        ram[c][a] = (c == 0) ? byte'(a) : byte'($urandom);
    repeat (3) @(negedge clk);
    apply_reset();

    // Slot sequence, freq=2 wrap on A, freq=8 period on B
    b_changes = 0; saw_wrap = 0; prev_a0 = 0; prev_a1 = 0;
    for (int f = 0; f < 100; f++) begin
      run_frames(1);
      if (f > 0) begin
        if (prev_a0 == 31 && obs_a[0] == 0) saw_wrap = 1;
        if (obs_a[1] != prev_a1) b_changes++;
      end
      prev_a0 = obs_a[0];
      prev_a1 = obs_a[1];
    end
    check_eq("a_wrap", saw_wrap, A_WRAP_EXP);
    check_eq("b_changes", b_changes, B_CHANGES_EXP);

    // Mix extremes
    mark_pending_skip();
    freq = '{10, 11, 12, 13, 14};
    vol  = '{15, 9, 9, 9, 9};
    en   = '{1, 0, 0, 0, 0};
    for (int a = 0; a < 32; a++) ram[0][a] = 8'sd127;
    run_frames(4);
    check_eq("mix_pos_max", mix_out, 1905);
    for (int a = 0; a < 32; a++) ram[0][a] = -8'sd128;
    run_frames(3);
    check_eq("mix_neg_one", mix_out, -1920);
    mark_pending_skip();
    for (int c = 0; c < 5; c++) begin
      vol[c] = 15;
      en[c]  = 1'b1;
      for (int a = 0; a < 32; a++) ram[c][a] = -8'sd128;
    end
    run_frames(3);
    check_eq("mix_neg_all", mix_out, -9600);

    // Mid-frame reset, then clear with pointer reset on channel C at pointer 17
    repeat (3) do_slot();
    apply_reset();
    freq = '{20, 20, 0, 20, 20};
    random_config();
    freq[2] = 0;
    for (int c = 0; c < 5; c++)
      for (int a = 0; a < 32; a++) ram[c][a] = byte'($urandom);
    run_frames(17);
    mark_pending_skip();
    freq[2] = 3;
    clr_vec = 5'b00100;
    wave_rst = 1'b1;
    run_frames(1);
`ifndef SCC_LOW_FREQ_MUTE_EN
    check_eq("clr_before", obs_a[2], 17);
`endif
    clr_vec = '0;
    wave_rst = 1'b0;
    run_frames(1);
`ifndef SCC_LOW_FREQ_MUTE_EN
    check_eq("clr_after", obs_a[2], 0);
`endif
    run_frames(3);
`ifndef SCC_LOW_FREQ_MUTE_EN
    check_eq("clr_reload_hold", obs_a[2], 0);
`endif
    run_frames(1);
`ifndef SCC_LOW_FREQ_MUTE_EN
    check_eq("clr_reload_adv", obs_a[2], 1);
`endif

    // Randomized frames with sparse clears and config changes
    for (int f = 0; f < 60; f++) begin
      if ($urandom_range(0, 3) == 0) begin
        mark_pending_skip();
        random_config();
      end
      clr_vec  = 5'($urandom & $urandom & $urandom);
      wave_rst = 1'($urandom_range(0, 1));
      run_frames(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
